// File: rtl/sqrt_pkg.sv
// Shared types and defaults for the square-root sequencing controller.
// The state encoding is exported so checkers can bind to the debug state port.
package sqrt_pkg;

   localparam int ITERS_DEF = 26;
   localparam int TAG_W_DEF = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } sqrt_state_e;

endpackage

// File: rtl/sqrt_iter_counter.sv
// Recurrence step counter: counts 0..ITERS-1 while enabled and wraps to 0 after the last step.
// clear has priority over enable.
module sqrt_iter_counter
   import sqrt_pkg::*;
#(
   parameter int ITERS = ITERS_DEF,
   parameter int CW    = $clog2(ITERS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   assign tc = (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/sqrt_controller.sv
// Sequencing controller for a digit-recurrence square-root unit: accept, ITERS
// recurrence steps, one normalize step, then hold the result until consumed.
//
// Handshakes: a request transfers on a cycle where in_valid && in_ready; a result
// transfers on a cycle where out_valid && out_ready. flush kills any operation; a
// flush coinciding with a result transfer still counts as that transfer.
module sqrt_controller
   import sqrt_pkg::*;
#(
   parameter int ITERS = ITERS_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_special,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     ld_en,
   output logic                     clr_acc,
   output logic                     iter_en,
   output logic [$clog2(ITERS)-1:0] iter_idx,
   output logic                     norm_en,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_special,
   output logic [TAG_W-1:0]         out_tag,
   output sqrt_state_e              dbg_state
);

   localparam int CW = $clog2(ITERS);

   sqrt_state_e   state;
   sqrt_state_e   state_nx;
   logic          accept;
   logic [CW-1:0] cnt;
   logic          cnt_tc;
   logic          cnt_clr;

   assign dbg_state = state;

   // Counter only runs in ITER; everywhere else it is held at zero.
   assign cnt_clr = flush || (state != S_ITER);

   sqrt_iter_counter #(
      .ITERS (ITERS),
      .CW    (CW)
   ) u_iter_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clr),
      .enable (iter_en),
      .count  (cnt),
      .tc     (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_tag     <= '0;
         out_special <= 1'b0;
      end else if (accept) begin
         out_tag     <= in_tag;
         out_special <= in_special;
      end
   end

   // Outputs are all forced inactive while rst is high, even if state is stale.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      ld_en     = 1'b0;
      clr_acc   = 1'b0;
      iter_en   = 1'b0;
      iter_idx  = '0;
      norm_en   = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      if (!rst) begin
         busy      = (state != S_IDLE);
         out_valid = (state == S_DONE);
         in_ready  = (state == S_IDLE) && !flush;
         accept    = in_ready && in_valid;
         ld_en     = accept;
         clr_acc   = accept || flush;
         iter_en   = (state == S_ITER) && !flush;
         norm_en   = (state == S_NORM) && !flush;
         if (state == S_ITER) begin
            iter_idx = cnt;
         end
         unique case (state)
            S_IDLE: if (accept) state_nx = in_special ? S_DONE : S_ITER;
            S_ITER: if (cnt_tc) state_nx = S_NORM;
            S_NORM: state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
         if (flush) begin
            state_nx = S_IDLE;
         end
      end
   end

endmodule
